mem_stage: RTL

Pipeline stage between the execute stage and write-back stage of the five-stage core. It takes the execute-stage result bundle, waits for the data-SRAM response of any load/store the execute stage issued, and aligns and extends load data. It buffers the response when write-back stalls and drops responses belonging to flushed instructions. It also exports its destination and result to decode for forwarding and load-use interlock.

---
 rtl/mem_stage_pkg.sv | 23 ++
 rtl/mem_stage_load_align.sv | 18 +
 rtl/mem_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared bus widths, bus field offsets and load-op bit indices
package mem_stage_pkg;
  localparam int ES_TO_MS_BUS_W = 78;
  localparam int MS_TO_WS_BUS_W = 71;
  localparam int ES_PC = 0;
  localparam int ES_RESULT = 32;
  localparam int ES_DEST = 64;
  localparam int ES_GR_WE = 69;
  localparam int ES_EX_IN = 70;
  localparam int ES_MEM_REQ = 71;
  localparam int ES_RES_FROM_MEM = 72;
  localparam int ES_LD_OP = 73;
  localparam int MS_PC = 0;
  localparam int MS_RESULT = 32;
  localparam int MS_DEST = 64;
  localparam int MS_GR_WE = 69;
  localparam int MS_EX = 70;
  localparam int LD_W = 0;
  localparam int LD_HU = 1;
  localparam int LD_H = 2;
  localparam int LD_BU = 3;
  localparam int LD_B = 4;
endpackage

// File: rtl/mem_stage_load_align.sv
// mem_stage_load_align: picks the addressed byte/half of a load word and extends it
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [4:0]  ld_op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);
  logic [15:0] h;
  logic [7:0]  b;
  assign h = offset[1] ? word[31:16] : word[15:0];
  assign b = offset[0] ? h[15:8] : h[7:0];
  assign data = ld_op[LD_B]  ? {{24{b[7]}}, b} :
                ld_op[LD_BU] ? {24'b0, b} :
                ld_op[LD_H]  ? {{16{h[15]}}, h} :
                ld_op[LD_HU] ? {16'b0, h} : word;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage; waits for SRAM data, aligns loads, drops responses of flushed requests
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_W-1:0] es_to_ms_bus,
  output logic                      ms_allowin,
  input  logic                      ws_allowin,
  output logic                      ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_W-1:0] ms_to_ws_bus,
  input  logic                      data_sram_data_ok,
  input  logic [31:0]               data_sram_rdata,
  input  logic                      flush,
  output logic                      ms_ex,
  output logic                      ms_fwd_valid,
  output logic [4:0]                ms_fwd_dest,
  output logic [31:0]               ms_fwd_data,
  output logic                      ms_fwd_pending
);
  logic [ES_TO_MS_BUS_W-1:0] bus_r;
  logic                      ms_valid;
  logic                      data_buf_valid;
  logic [31:0]               data_buf;
  logic [1:0]                discard_cnt;
  logic [4:0]  ld_op;
  logic        res_from_mem;
  logic        mem_req;
  logic        ex_in;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] result;
  logic [31:0] pc;
  logic        data_ok_acc;
  logic        need_data;
  logic        have_data;
  logic        ms_ready_go;
  logic        leave;
  logic        cnt_inc;
  logic        cnt_dec;
  logic [31:0] word;
  logic [31:0] extracted;
  logic [31:0] final_result;
  assign ld_op        = bus_r[ES_LD_OP +: 5];
  assign res_from_mem = bus_r[ES_RES_FROM_MEM];
  assign mem_req      = bus_r[ES_MEM_REQ];
  assign ex_in        = bus_r[ES_EX_IN];
  assign gr_we        = bus_r[ES_GR_WE];
  assign dest         = bus_r[ES_DEST +: 5];
  assign result       = bus_r[ES_RESULT +: 32];
  assign pc           = bus_r[ES_PC +: 32];
  assign data_ok_acc    = data_sram_data_ok & (discard_cnt == 2'd0);
  assign need_data      = ms_valid & mem_req;
  assign have_data      = data_buf_valid | data_ok_acc;
  assign ms_ready_go    = !need_data | have_data;
  assign ms_allowin     = !ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go & !flush;
  assign leave          = ms_to_ws_valid & ws_allowin;
  assign cnt_inc        = flush & need_data & !have_data;
  assign cnt_dec        = data_sram_data_ok & (discard_cnt != 2'd0);
  assign word           = data_buf_valid ? data_buf : data_sram_rdata;
  mem_stage_load_align u_align (
    .ld_op  (ld_op),
    .offset (result[1:0]),
    .word   (word),
    .data   (extracted)
  );
  assign final_result = res_from_mem ? extracted : result;
  assign ms_to_ws_bus[MS_EX]           = ex_in;
  assign ms_to_ws_bus[MS_GR_WE]        = gr_we;
  assign ms_to_ws_bus[MS_DEST +: 5]    = dest;
  assign ms_to_ws_bus[MS_RESULT +: 32] = final_result;
  assign ms_to_ws_bus[MS_PC +: 32]     = pc;
  assign ms_ex          = ms_valid & ex_in;
  assign ms_fwd_valid   = ms_valid & gr_we & (dest != 5'd0);
  assign ms_fwd_dest    = ms_valid ? dest : 5'd0;
  assign ms_fwd_data    = ms_valid ? final_result : 32'd0;
  assign ms_fwd_pending = need_data & res_from_mem & !have_data;
  // stage occupancy and bundle register; flush beats an incoming bundle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      bus_r    <= '0;
    end else begin
      if (flush) ms_valid <= 1'b0;
      else if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid && ms_allowin) bus_r <= es_to_ms_bus;
    end
  end
  // hold load data that arrived while write-back was stalled
  always_ff @(posedge clk) begin
    if (!resetn || flush || leave) data_buf_valid <= 1'b0;
    else if (data_ok_acc && need_data && !ws_allowin) data_buf_valid <= 1'b1;
  end
  // data word captured alongside the buffer valid flag
  always_ff @(posedge clk) begin
    if (data_ok_acc && need_data && !ws_allowin) data_buf <= data_sram_rdata;
  end
  // count responses still in flight for flushed requests
  always_ff @(posedge clk) begin
    if (!resetn) discard_cnt <= 2'd0;
    else if (cnt_inc && !cnt_dec && discard_cnt != 2'd3) discard_cnt <= discard_cnt + 2'd1;
    else if (cnt_dec && !cnt_inc) discard_cnt <= discard_cnt - 2'd1;
  end
endmodule
